// File: rtl/or_accumulator.sv
// Purpose: ORs a batch of up to DEPTH words together and presents the OR plus word count.
// Latency: result valid one cycle after the closing accept or flush edge.
// Backpressure: input is blocked while a result waits; the result holds until out_ready.
module or_accumulator #(
  parameter int S     = 3,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [(2**S)-1:0]   in_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(2**S)-1:0]   out_data,
  output logic [7:0]          out_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [(2**S)-1:0]   acc_q, acc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [(2**S)-1:0]   out_data_q, out_data_d;
  logic [7:0]          out_count_q, out_count_d;
  logic                in_ready_q, in_ready_d;
  logic                accept;

  // Next-state logic: fold accepted words in, close the batch on a full count or flush,
  // release the held result on the output handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    accept      = in_valid & in_ready_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q | in_data;
          cnt_d = cnt_q + 8'd1;
        end
        // A flush with nothing collected and nothing arriving is a no-op.
        if ((accept && ((cnt_d == 8'(DEPTH)) || flush)) || (flush && (cnt_q != 8'd0))) begin
          state_d     = HOLD;
          out_data_d  = acc_d;
          out_count_d = cnt_d;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    // Ready is registered so it stays low through reset and rises on the first edge after it.
    in_ready_d = (state_d == ACCUM);
  end

  // State and datapath registers; reset discards any partial or pending batch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= 8'd0;
      out_data_q  <= '0;
      out_count_q <= 8'd0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: doc/or_accumulator.md
OR_ACCUMULATOR -- requirements
Module: or_accumulator

Interface
REQ-001 The block SHALL have parameter S, default 3, meaning data width is 2**S bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning words per batch; legal range 2..255.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  upstream word present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 The block SHALL have port in_data  input  2**S  word to OR into the accumulator.
REQ-008 The block SHALL have port flush  input  1  close the current batch early.
REQ-009 The block SHALL have port out_valid  output  1  batch result present.
REQ-010 The block SHALL have port out_ready  input  1  downstream takes the result.
REQ-011 The block SHALL have port out_data  output  2**S  bitwise OR of all words in the batch.
REQ-012 The block SHALL have port out_count  output  8  number of words in the batch.

Function
REQ-013 The block SHALL implement two states: ACCUM and HOLD.
REQ-014 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 Accept SHALL mean in_valid=1 and in_ready=1 at a rising edge.
REQ-017 On accept, acc SHALL become acc | in_data and cnt SHALL become cnt+1.
REQ-018 The accept that brings cnt to DEPTH SHALL move the state to HOLD on that same edge.
REQ-019 In ACCUM, flush=1 with cnt>0, or with a same-cycle accept, SHALL move the state to HOLD.
REQ-020 A word accepted on the same edge as flush SHALL be included in the batch.
REQ-021 In ACCUM, flush=1 with cnt=0 and no accept SHALL be ignored; state, acc and cnt stay unchanged.
REQ-022 Entering HOLD SHALL register out_data=acc (including the final word) and out_count=cnt.
REQ-023 out_valid SHALL rise one cycle after the closing edge, giving latency 1 from the last accept.
REQ-024 In HOLD, out_data and out_count SHALL stay stable until the handshake completes.
REQ-025 In HOLD, flush and in_valid SHALL be ignored.
REQ-026 In HOLD, out_ready=1 at an edge SHALL clear acc and cnt to 0 and return the state to ACCUM.
REQ-027 in_ready SHALL not re-assert until the cycle after the output handshake; there is no bypass.
REQ-028 out_data and out_count SHALL hold their last values in ACCUM; they are valid only while out_valid=1.
REQ-029 All outputs SHALL be driven from registers or from the state register only; there are no combinational paths from inputs to outputs.

Reset
REQ-030 rst_n=0 SHALL immediately force the state to ACCUM, and acc, cnt, out_data and out_count to 0, independent of clk.
REQ-031 During reset, out_valid SHALL be 0 and in_ready SHALL be 0.
REQ-032 in_ready SHALL go to 1 on the first rising edge after rst_n deasserts.
REQ-033 Reset asserted mid-batch or in HOLD SHALL discard the partial or pending result; no output SHALL follow.

Verification (S=3, DEPTH=4)
REQ-034 Full batch: accept 0xFC, 0x01, 0x80, 0x02 on consecutive cycles with out_ready=1 -> out_valid for exactly 1 cycle with out_data=0xFF and out_count=4, and in_ready=0 during that cycle.
REQ-035 Early flush: accept 0x80, then 0x01 together with flush=1 -> out_data=0x81 and out_count=2.
REQ-036 Backpressure: after a full batch, hold out_ready=0 for 3 cycles while in_valid=1 with data 0xAA -> out_data is stable, in_ready=0, and 0xAA is not absorbed; the next batch starts from acc=0.
REQ-037 Empty flush: pulse flush=1 with cnt=0 and in_valid=0 -> no out_valid; a following batch of 0x10 x4 gives out_data=0x10 and out_count=4.
REQ-038 Reset mid-operation: accept 0x0F, 0xF0, then pulse rst_n low between edges -> outputs clear immediately; accepting 0x01 x4 afterwards gives out_data=0x01 and out_count=4.
